// File: rtl/riscv_mc_core.sv
// Multi-cycle RV32I/RV32E integer core: FETCH -> EXEC -> WB, three cycles minimum per instruction.
// Fetch holds imem_req/imem_addr until imem_ready; illegal or misaligned-target instructions halt until reset.
module riscv_mc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        retire,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        halted
);
    localparam int AW = (NUM_REGS == 16) ? 4 : 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] next_pc_q;
    logic [31:0] rf [NUM_REGS];

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] pc_plus4;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign funct7 = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf[rs1[AW-1:0]];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf[rs2[AW-1:0]];
    assign pc_plus4 = pc + 32'd4;

    // alt selects SUB for funct3=0 and arithmetic shift for funct3=5
    function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = alt ? (a - b) : (a + b);
            3'd1:    r = a << b[4:0];
            3'd2:    r = {31'd0, $signed(a) < $signed(b)};
            3'd3:    r = {31'd0, a < b};
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    logic        illegal;
    logic        writes;
    logic        taken;
    logic        use_rd;
    logic        use_rs1;
    logic        use_rs2;
    logic [31:0] result;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        misaligned;
    logic        wen;

    always_comb begin
        illegal = 1'b0;
        writes  = 1'b0;
        taken   = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        result  = 32'd0;
        target  = pc_plus4;
        case (opcode)
            OPC_OP: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                writes  = 1'b1;
                illegal = !((funct7 == 7'h00) ||
                            (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5)));
                result  = alu(funct3, ir[30], rs1_val, rs2_val);
            end
            OPC_OP_IMM: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                writes  = 1'b1;
                if (funct3 == 3'd1)
                    illegal = (funct7 != 7'h00);
                else if (funct3 == 3'd5)
                    illegal = !(funct7 == 7'h00 || funct7 == 7'h20);
                result = alu(funct3, (funct3 == 3'd5) && ir[30], rs1_val, imm_i);
            end
            OPC_LUI: begin
                use_rd = 1'b1;
                writes = 1'b1;
                result = imm_u;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1;
                writes = 1'b1;
                result = pc + imm_u;
            end
            OPC_JAL: begin
                use_rd = 1'b1;
                writes = 1'b1;
                taken  = 1'b1;
                result = pc_plus4;
                target = pc + imm_j;
            end
            OPC_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                writes  = 1'b1;
                taken   = 1'b1;
                illegal = (funct3 != 3'd0);
                result  = pc_plus4;
                target  = (rs1_val + imm_i) & ~32'd1;
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct3)
                    3'd0:    taken = (rs1_val == rs2_val);
                    3'd1:    taken = (rs1_val != rs2_val);
                    3'd4:    taken = ($signed(rs1_val) <  $signed(rs2_val));
                    3'd5:    taken = ($signed(rs1_val) >= $signed(rs2_val));
                    3'd6:    taken = (rs1_val <  rs2_val);
                    3'd7:    taken = (rs1_val >= rs2_val);
                    default: illegal = 1'b1;
                endcase
                if (taken)
                    target = pc + imm_b;
            end
            default: illegal = 1'b1;
        endcase
        // RV32E has no x16..x31: any referenced register field with bit 4 set traps
        if (NUM_REGS == 16 &&
            ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])))
            illegal = 1'b1;
    end

    assign misaligned = taken && (target[1:0] != 2'b00);
    assign next_pc    = taken ? target : pc_plus4;
    assign wen        = writes && (rd != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= 32'd0;
            next_pc_q <= 32'd0;
            halted    <= 1'b0;
            retire    <= 1'b0;
            wb_en     <= 1'b0;
            wb_addr   <= 5'd0;
            wb_data   <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (illegal || misaligned) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        state     <= WB;
                        retire    <= 1'b1;
                        wb_en     <= wen;
                        wb_addr   <= wen ? rd : 5'd0;
                        wb_data   <= wen ? result : 32'd0;
                        next_pc_q <= next_pc;
                    end
                end
                WB: begin
                    pc      <= next_pc_q;
                    retire  <= 1'b0;
                    wb_en   <= 1'b0;
                    wb_addr <= 5'd0;
                    wb_data <= 32'd0;
                    state   <= FETCH;
                end
                default: state <= HALT;
            endcase
        end
    end

    // The write lands on the edge that leaves WB, so the next EXEC sees it
    always_ff @(posedge clk) begin
        if (!reset && state == WB && wb_en)
            rf[wb_addr[AW-1:0]] <= wb_data;
    end

    assign imem_req        = (state == FETCH) && !reset;
    assign imem_addr       = pc;
    assign pc_out          = pc;
    assign instruction_out = ir;

endmodule

// File: tb/tb_riscv_mc_core.sv
// Directed bench for riscv_mc_core: an RV32I build at 0x100 and an RV32E build at 0x0.
module tb_riscv_mc_core;
    logic        clk = 1'b0;
    logic        rst;
    logic        rst_e;
    logic        rdy;
    logic        req,  req_e;
    logic [31:0] addr, addr_e;
    logic [31:0] rdata, rdata_e;
    logic [31:0] pcv,  pcv_e;
    logic [31:0] irv,  irv_e;
    logic        ret,  ret_e;
    logic        wen,  wen_e;
    logic [4:0]  wa,   wa_e;
    logic [31:0] wd,   wd_e;
    logic        hlt,  hlt_e;

    logic [31:0] mem   [256];
    logic [31:0] mem_e [256];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_ret   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign rdata   = mem[addr[9:2]];
    assign rdata_e = mem_e[addr_e[9:2]];

    riscv_mc_core #(.RESET_PC(32'h0000_0100), .NUM_REGS(32)) dut (
        .clk(clk), .reset(rst), .imem_req(req), .imem_addr(addr),
        .imem_ready(rdy), .imem_rdata(rdata), .pc_out(pcv), .instruction_out(irv),
        .retire(ret), .wb_en(wen), .wb_addr(wa), .wb_data(wd), .halted(hlt)
    );

    riscv_mc_core #(.RESET_PC(32'h0000_0000), .NUM_REGS(16)) dut_e (
        .clk(clk), .reset(rst_e), .imem_req(req_e), .imem_addr(addr_e),
        .imem_ready(1'b1), .imem_rdata(rdata_e), .pc_out(pcv_e), .instruction_out(irv_e),
        .retire(ret_e), .wb_en(wen_e), .wb_addr(wa_e), .wb_data(wd_e), .halted(hlt_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until retire or halt of the selected core, at most budget cycles
    task automatic wait_ret(input bit e, input int budget, output bit got);
        bit done;
        done = 1'b0;
        got  = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            if (e ? ret_e : ret) begin
                got  = 1'b1;
                done = 1'b1;
            end else if (e ? hlt_e : hlt) begin
                done = 1'b1;
            end
        end
    endtask

    task automatic retire_chk(input string tag, input bit e, input bit en,
                              input logic [4:0] a, input logic [31:0] d, input int gap);
        bit got;
        wait_ret(e, 20, got);
        chk({tag, "_retire"}, {31'd0, got}, 32'd1);
        chk({tag, "_wb_en"}, {31'd0, e ? wen_e : wen}, {31'd0, en});
        if (en) begin
            chk({tag, "_wb_addr"}, {27'd0, e ? wa_e : wa}, {27'd0, a});
            chk({tag, "_wb_data"}, e ? wd_e : wd, d);
        end
        if (gap > 0)
            chk({tag, "_gap"}, cyc - last_ret, gap);
        last_ret = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'd0;
            mem_e[i] = 32'd0;
        end
        mem[64]  = 32'hFFB00093; // 0x100 ADDI x1,x0,-5
        mem[65]  = 32'h00300113; // 0x104 ADDI x2,x0,3
        mem[66]  = 32'h0020A1B3; // 0x108 SLT  x3,x1,x2
        mem[67]  = 32'h0020B233; // 0x10C SLTU x4,x1,x2
        mem[68]  = 32'h4020D2B3; // 0x110 SRA  x5,x1,x2
        mem[69]  = 32'h01000367; // 0x114 JALR x6,x0,16
        mem[4]   = 32'hFE209CE3; // 0x010 BNE  x1,x2,-8
        mem[2]   = 32'h20000113; // 0x008 ADDI x2,x0,0x200
        mem[3]   = 32'h001100E7; // 0x00C JALR x1,x2,1
        mem[128] = 32'hFFC00067; // 0x200 JALR x0,x0,-4
        mem[255] = 32'h008003EF; // 0xFFFFFFFC JAL x7,+8
        mem[1]   = 32'h03C0046F; // 0x004 JAL  x8,+0x3C
        mem[16]  = 32'h123454B7; // 0x040 LUI  x9,0x12345
        mem[17]  = 32'h00001517; // 0x044 AUIPC x10,1
        mem[18]  = 32'h00A485B3; // 0x048 ADD  x11,x9,x10
        mem[19]  = 32'h40110633; // 0x04C SUB  x12,x2,x1
        mem[20]  = 32'h00461693; // 0x050 SLLI x13,x12,4
        mem[21]  = 32'hFFF0C713; // 0x054 XORI x14,x1,-1
        mem[22]  = 32'h40475793; // 0x058 SRAI x15,x14,4
        mem[23]  = 32'h00208463; // 0x05C BEQ  x1,x2,+8 (not taken)
        mem[24]  = 32'h0020086F; // 0x060 JAL  x16,+2 (misaligned)

        mem_e[0] = 32'h00700093; // ADDI x1,x0,7
        mem_e[1] = 32'h00900113; // ADDI x2,x0,9
        mem_e[2] = 32'h00500013; // ADDI x0,x0,5
        mem_e[3] = 32'h002087B3; // ADD  x15,x1,x2
        mem_e[4] = 32'h000001B3; // ADD  x3,x0,x0
        mem_e[5] = 32'h002088B3; // ADD  x17,x1,x2

        rst   = 1'b1;
        rst_e = 1'b1;
        rdy   = 1'b1;

        repeat (2) begin
            step();
            chk("rst_req", {31'd0, req}, 32'd0);
        end
        chk("rst_pc", pcv, 32'h100);
        chk("rst_ir", irv, 32'd0);
        chk("rst_retire", {31'd0, ret}, 32'd0);
        chk("rst_halted", {31'd0, hlt}, 32'd0);
        chk("rst_wb_data", wd, 32'd0);

        rst = 1'b0;
        #1;
        chk("first_req", {31'd0, req}, 32'd1);
        chk("first_addr", addr, 32'h100);

        retire_chk("addi_x1", 1'b0, 1'b1, 5'd1, 32'hFFFF_FFFB, 0);

        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            else step();
            chk("stall_addr", addr, 32'h104);
            chk("stall_req", {31'd0, req}, 32'd1);
        end
        rdy = 1'b1;

        retire_chk("addi_x2", 1'b0, 1'b1, 5'd2, 32'd3, 7);
        retire_chk("slt_x3", 1'b0, 1'b1, 5'd3, 32'd1, 3);
        chk("slt_pc_out", pcv, 32'h108);
        chk("slt_ir_out", irv, 32'h0020A1B3);
        retire_chk("sltu_x4", 1'b0, 1'b1, 5'd4, 32'd0, 3);
        retire_chk("sra_x5", 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 3);
        retire_chk("jalr_x6", 1'b0, 1'b1, 5'd6, 32'h118, 3);
        step();
        chk("jalr_target", addr, 32'h10);

        retire_chk("bne", 1'b0, 1'b0, 5'd0, 32'd0, 0);
        step();
        chk("bne_target", addr, 32'h08);
        retire_chk("addi_x2b", 1'b0, 1'b1, 5'd2, 32'h200, 0);
        retire_chk("jalr_x1", 1'b0, 1'b1, 5'd1, 32'h10, 0);
        step();
        chk("jalr_lsb_clear", addr, 32'h200);
        retire_chk("jalr_x0", 1'b0, 1'b0, 5'd0, 32'd0, 0);
        step();
        chk("jalr_neg_target", addr, 32'hFFFF_FFFC);
        retire_chk("jal_wrap_x7", 1'b0, 1'b1, 5'd7, 32'd0, 0);
        step();
        chk("jal_wrap_target", addr, 32'h4);

        retire_chk("jal_x8", 1'b0, 1'b1, 5'd8, 32'h8, 0);
        retire_chk("lui_x9", 1'b0, 1'b1, 5'd9, 32'h1234_5000, 0);
        retire_chk("auipc_x10", 1'b0, 1'b1, 5'd10, 32'h1044, 0);
        retire_chk("add_x11", 1'b0, 1'b1, 5'd11, 32'h1234_6044, 0);
        retire_chk("sub_x12", 1'b0, 1'b1, 5'd12, 32'h1F0, 0);
        retire_chk("slli_x13", 1'b0, 1'b1, 5'd13, 32'h1F00, 0);
        retire_chk("xori_x14", 1'b0, 1'b1, 5'd14, 32'hFFFF_FFEF, 0);
        retire_chk("srai_x15", 1'b0, 1'b1, 5'd15, 32'hFFFF_FFFE, 0);
        retire_chk("beq_nt", 1'b0, 1'b0, 5'd0, 32'd0, 0);
        step();
        chk("beq_fallthrough", addr, 32'h60);

        wait_ret(1'b0, 10, got);
        chk("misalign_no_retire", {31'd0, got}, 32'd0);
        chk("misalign_halted", {31'd0, hlt}, 32'd1);
        chk("misalign_wb_en", {31'd0, wen}, 32'd0);
        repeat (3) begin
            step();
            chk("halt_req", {31'd0, req}, 32'd0);
            chk("halt_retire", {31'd0, ret}, 32'd0);
        end

        mem[64] = 32'h00002083; // LW x1,0(x0): unsupported opcode, must halt
        rst = 1'b1;
        step();
        chk("rerst_halted", {31'd0, hlt}, 32'd0);
        chk("rerst_req", {31'd0, req}, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("load_exec_halted", {31'd0, hlt}, 32'd0);
        step();
        chk("load_halted", {31'd0, hlt}, 32'd1);
        chk("load_retire", {31'd0, ret}, 32'd0);
        repeat (3) begin
            step();
            chk("load_halt_req", {31'd0, req}, 32'd0);
        end

        rst_e = 1'b0;
        last_ret = cyc;
        retire_chk("e_addi_x1", 1'b1, 1'b1, 5'd1, 32'd7, 2);
        retire_chk("e_addi_x2", 1'b1, 1'b1, 5'd2, 32'd9, 3);
        retire_chk("e_addi_x0", 1'b1, 1'b0, 5'd0, 32'd0, 3);
        retire_chk("e_add_x15", 1'b1, 1'b1, 5'd15, 32'd16, 3);
        retire_chk("e_add_x3", 1'b1, 1'b1, 5'd3, 32'd0, 3);
        wait_ret(1'b1, 10, got);
        chk("e_x17_no_retire", {31'd0, got}, 32'd0);
        chk("e_x17_halted", {31'd0, hlt_e}, 32'd1);
        step();
        chk("e_halt_req", {31'd0, req_e}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
